// File: rtl/series_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : series_pkg
//  Description : Shared defaults, fixed-point one and sine-series coefficient
//                builder for the Taylor-series evaluation unit. Imported by
//                both the controller and the datapath so N_TERMS agrees.
//  Revision    : 1.0 - initial release
// ============================================================================
package series_pkg;

    localparam int WIDTH_DEF   = 16;
    localparam int FRAC_DEF    = 14;
    localparam int N_TERMS_DEF = 8;
    localparam int CNT_W_DEF   = 3;

    // Fixed-point 1.0 at the default fractional width
    localparam int ONE = 1 << FRAC_DEF;

    // Sine-series coefficient 1/((2k+2)(2k+3)) in Q0.frac, truncated;
    // indices past the last term read as zero.
    function automatic int coef_calc(input int k, input int frac, input int n_terms);
        if (k >= n_terms) begin
            return 0;
        end
        return (1 << frac) / ((2 * k + 2) * (2 * k + 3));
    endfunction

endpackage
`default_nettype wire

// File: rtl/series_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module      : series_datapath_if
//  Description : Strobe/status bundle between the series controller (master)
//                and the series datapath (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface series_datapath_if
    import series_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic signed [WIDTH-1:0] x_in;
    logic                    ld_x;
    logic                    init_t;
    logic                    ld_t;
    logic                    init_r;
    logic                    ld_r;
    logic                    z_c;
    logic                    en_c;
    logic                    s_mux;
    logic                    s_signop;
    logic                    co;
    logic                    flag;
    logic signed [WIDTH-1:0] result;

    modport master (
        output x_in, ld_x, init_t, ld_t, init_r, ld_r, z_c, en_c, s_mux, s_signop,
        input  co, flag, result
    );

    modport slave (
        input  x_in, ld_x, init_t, ld_t, init_r, ld_r, z_c, en_c, s_mux, s_signop,
        output co, flag, result
    );

endinterface
`default_nettype wire

// File: rtl/series_coef_rom.sv
`default_nettype none
// ============================================================================
//  Module      : series_coef_rom
//  Description : Combinational coefficient lookup indexed by the term counter.
//                Table contents are constants built from the package function.
//  Revision    : 1.0 - initial release
// ============================================================================
module series_coef_rom
    import series_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int FRAC    = FRAC_DEF,
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  wire logic        [CNT_W-1:0] i_c,
    output logic signed      [WIDTH-1:0] o_coef
);

    localparam int c_DEPTH = 1 << CNT_W;

    logic signed [WIDTH-1:0] w_tab [c_DEPTH];

    // One constant entry per counter value; unused slots evaluate to zero
    for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_tab
        localparam int c_VAL = coef_calc(gi, FRAC, N_TERMS);
        assign w_tab[gi] = WIDTH'(c_VAL);
    end

    assign o_coef = w_tab[i_c];

endmodule
`default_nettype wire

// File: rtl/series_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : series_datapath
//  Description : Fixed-point datapath for the Taylor-series unit. Holds the
//                operand x, pipelined square xx, running term t, result r and
//                term counter c; driven by controller strobes.
//                Optional feature macro: SERIES_SAT_EN (saturating accumulate;
//                default build wraps modulo 2^WIDTH).
//  Revision    : 1.0 - initial release
// ============================================================================
module series_datapath
    import series_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int FRAC    = FRAC_DEF,
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  wire logic        clk,
    input  wire logic        rst,     // synchronous, active low
    series_datapath_if.slave bus
);

    localparam logic signed [WIDTH-1:0] c_ONE  = WIDTH'(1 << FRAC);
    localparam logic        [CNT_W-1:0] c_LAST = CNT_W'(N_TERMS - 1);

    logic signed [WIDTH-1:0] r_x;
    logic signed [WIDTH-1:0] r_xx;
    logic signed [WIDTH-1:0] r_t;
    logic signed [WIDTH-1:0] r_r;
    logic        [CNT_W-1:0] r_c;
    logic                    r_ldx_q;

    logic signed [2*WIDTH-1:0] w_sq;
    logic signed [WIDTH-1:0]   w_xx_next;
    logic signed [2*WIDTH-1:0] w_tx;
    logic signed [2*WIDTH-1:0] w_txs;
    logic signed [3*WIDTH-1:0] w_tc;
    logic signed [WIDTH-1:0]   w_t_next;
    logic signed [WIDTH-1:0]   w_coef;
    logic signed [WIDTH-1:0]   w_acc;

    series_coef_rom #(
        .WIDTH   (WIDTH),
        .FRAC    (FRAC),
        .N_TERMS (N_TERMS),
        .CNT_W   (CNT_W)
    ) u_coef_rom (
        .i_c    (r_c),
        .o_coef (w_coef)
    );

    // Full-precision products; arithmetic shifts truncate toward -inf
    assign w_sq      = (2*WIDTH)'(r_x) * (2*WIDTH)'(r_x);
    assign w_xx_next = WIDTH'(w_sq >>> FRAC);
    assign w_tx      = (2*WIDTH)'(r_t) * (2*WIDTH)'(r_xx);
    assign w_txs     = w_tx >>> FRAC;
    assign w_tc      = (3*WIDTH)'(w_txs) * (3*WIDTH)'(w_coef);
    assign w_t_next  = WIDTH'(w_tc >>> FRAC);

`ifdef SERIES_SAT_EN
    localparam logic signed [WIDTH-1:0] c_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] c_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH:0] w_wide;

    // One guard bit exposes overflow; clamp when the top two bits disagree
    assign w_wide = bus.s_signop ? ({r_r[WIDTH-1], r_r} - {r_t[WIDTH-1], r_t})
                                 : ({r_r[WIDTH-1], r_r} + {r_t[WIDTH-1], r_t});
    assign w_acc  = (w_wide[WIDTH] != w_wide[WIDTH-1])
                  ? (w_wide[WIDTH] ? c_MIN : c_MAX)
                  : w_wide[WIDTH-1:0];
`else
    assign w_acc  = bus.s_signop ? (r_r - r_t) : (r_r + r_t);
`endif

    // Operand load and one-cycle pipelined square of the freshly loaded x
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_x     <= '0;
            r_xx    <= '0;
            r_ldx_q <= 1'b0;
        end else begin
            r_ldx_q <= bus.ld_x;
            if (bus.ld_x) begin
                r_x <= bus.x_in;
            end
            if (r_ldx_q) begin
                r_xx <= w_xx_next;
            end
        end
    end

    // Term register: init wins over the next-term update
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_t <= '0;
        end else if (bus.init_t) begin
            r_t <= bus.s_mux ? c_ONE : r_x;
        end else if (bus.ld_t) begin
            r_t <= w_t_next;
        end
    end

    // Result accumulator: clear wins; accumulate uses the pre-edge term
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_r <= '0;
        end else if (bus.init_r) begin
            r_r <= '0;
        end else if (bus.ld_r) begin
            r_r <= w_acc;
        end
    end

    // Term counter: clear wins; wraps to zero after the last term
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_c <= '0;
        end else if (bus.z_c) begin
            r_c <= '0;
        end else if (bus.en_c) begin
            r_c <= (r_c == c_LAST) ? '0 : r_c + 1'b1;
        end
    end

    assign bus.co     = (r_c == c_LAST);
    assign bus.flag   = (r_t == '0);
    assign bus.result = r_r;

endmodule
`default_nettype wire

// File: tb/tb_series_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_series_datapath
//  Description : Self-checking bench for series_datapath: directed scenarios
//                plus randomized strobes against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_series_datapath;
    import series_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural state: integers, values kept as signed 16-bit numbers
    longint m_x, m_xx, m_t, m_r;
    int     m_c;
    bit     m_ldx_prev;

    series_datapath_if #(.WIDTH(16)) bus ();

    series_datapath dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint s16(input longint v);
        longint u;
        u = v & 64'hFFFF;
        return (u >= 32768) ? u - 65536 : u;
    endfunction

    // Sine-series coefficient straight from its definition
    function automatic longint coef(input int k);
        if (k >= 8) return 0;
        return 16384 / ((2 * k + 2) * (2 * k + 3));
    endfunction

    task automatic model_edge();
        longint nx, nxx, nt, nr, acc;
        int     nc;
        if (!rst) begin
            m_x = 0; m_xx = 0; m_t = 0; m_r = 0; m_c = 0; m_ldx_prev = 0;
            return;
        end
        nx  = bus.ld_x ? s16(longint'(bus.x_in)) : m_x;
        nxx = m_ldx_prev ? s16((m_x * m_x) >>> 14) : m_xx;
        if (bus.init_t)    nt = bus.s_mux ? 16384 : m_x;
        else if (bus.ld_t) nt = s16((((m_t * m_xx) >>> 14) * coef(m_c)) >>> 14);
        else               nt = m_t;
        acc = bus.s_signop ? m_r - m_t : m_r + m_t;
`ifdef SERIES_SAT_EN
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
`else
        acc = s16(acc);
`endif
        if (bus.init_r)    nr = 0;
        else if (bus.ld_r) nr = acc;
        else               nr = m_r;
        if (bus.z_c)       nc = 0;
        else if (bus.en_c) nc = (m_c == 7) ? 0 : m_c + 1;
        else               nc = m_c;
        m_x = nx; m_xx = nxx; m_t = nt; m_r = nr; m_c = nc;
        m_ldx_prev = bus.ld_x;
    endtask

    task automatic idle();
        bus.ld_x = 0; bus.init_t = 0; bus.ld_t = 0; bus.init_r = 0;
        bus.ld_r = 0; bus.z_c = 0; bus.en_c = 0; bus.s_mux = 0; bus.s_signop = 0;
    endtask

    // One clock: update model at the edge, compare outputs 1 time unit later
    task automatic step();
        logic [15:0] er;
        @(posedge clk);
        model_edge();
        #1;
        er = m_r[15:0];
        chk("result", {16'h0, bus.result}, {16'h0, er});
        chk("co",     {31'h0, bus.co},     {31'h0, (m_c == 7)});
        chk("flag",   {31'h0, bus.flag},   {31'h0, (m_t == 0)});
        idle();
    endtask

    // Load r with value v via x -> t -> accumulate
    task automatic load_r(input logic [15:0] v);
        bus.x_in = v; bus.ld_x = 1; step();
        bus.init_t = 1; bus.init_r = 1; step();
        bus.ld_r = 1; step();
    endtask

    initial begin
        int res;
        logic [15:0] sat_exp;
        idle();
        bus.x_in = '0;
        m_x = 0; m_xx = 0; m_t = 0; m_r = 0; m_c = 0; m_ldx_prev = 0;

        // Reset state
        rst = 0; step(); step();
        rst = 1;
        chk("rst_result", {16'h0, bus.result}, 32'h0);
        chk("rst_flag",   {31'h0, bus.flag},   32'h1);
        chk("rst_co",     {31'h0, bus.co},     32'h0);

        // Reset mid-run
        load_r(16'h1234);
        chk("r_loaded", {16'h0, bus.result}, 32'h1234);
        rst = 0; step(); step();
        rst = 1; step();
        chk("midrst_result", {16'h0, bus.result}, 32'h0);
        chk("midrst_flag",   {31'h0, bus.flag},   32'h1);
        chk("midrst_co",     {31'h0, bus.co},     32'h0);

        // Counter terminal count and wrap
        bus.z_c = 1; step();
        for (int i = 1; i <= 7; i++) begin
            bus.en_c = 1; step();
            chk("cnt_co", {31'h0, bus.co}, {31'h0, (i == 7)});
        end
        bus.en_c = 1; step();
        chk("cnt_wrap_co", {31'h0, bus.co}, 32'h0);
        bus.en_c = 1; step();
        bus.z_c = 1; bus.en_c = 1; step();
        for (int i = 1; i <= 7; i++) begin
            bus.en_c = 1; step();
        end
        chk("zc_wins_co", {31'h0, bus.co}, 32'h1);

        // Full sine of 0.5
        bus.x_in = 16'h2000; bus.ld_x = 1; step();
        bus.init_t = 1; bus.init_r = 1; bus.z_c = 1; step();
        for (int i = 0; i < 8; i++) begin
            bus.ld_r = 1; bus.s_signop = i[0]; bus.ld_t = 1; bus.en_c = 1; step();
        end
        res = int'(bus.result);
        chk("sine_tol", {31'h0, (res >= 32'sh1EAF - 4 && res <= 32'sh1EAF + 4)}, 32'h1);

        // Early termination
        bus.x_in = '0; bus.ld_x = 1; step();
        bus.init_t = 1; step();
        chk("early_flag", {31'h0, bus.flag}, 32'h1);

        // Saturation / wrap
        load_r(16'h7000);
        bus.x_in = 16'h2000; bus.ld_x = 1; step();
        bus.init_t = 1; step();
        bus.ld_r = 1; step();
`ifdef SERIES_SAT_EN
        sat_exp = 16'h7FFF;
`else
        sat_exp = 16'h9000;
`endif
        chk("sat_result", {16'h0, bus.result}, {16'h0, sat_exp});

        // init_t beats ld_t
        bus.init_r = 1; step();
        bus.init_t = 1; bus.ld_t = 1; bus.s_mux = 1; step();
        bus.ld_r = 1; step();
        chk("prio_t", {16'h0, bus.result}, 32'h4000);

        // Randomized strobes against the model
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 49) != 0);
            bus.x_in     = 16'($urandom);
            bus.ld_x     = ($urandom_range(0, 3) == 0);
            bus.init_t   = ($urandom_range(0, 4) == 0);
            bus.ld_t     = 1'($urandom);
            bus.init_r   = ($urandom_range(0, 7) == 0);
            bus.ld_r     = 1'($urandom);
            bus.z_c      = ($urandom_range(0, 9) == 0);
            bus.en_c     = 1'($urandom);
            bus.s_mux    = 1'($urandom);
            bus.s_signop = 1'($urandom);
            step();
        end
        rst = 1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
